// File: rtl/ryuki_datatypes.sv
// ryuki_datatypes: shared types for the instruction fetch sequencer.
// Holds the sequencer FSM state enum and the response bundle layout.
package ryuki_datatypes;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_LAT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_seq_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] data;
        logic [FETCH_LAT_W-1:0]  latency;
    } fetch_resp_t;

endpackage

// File: rtl/fetch_pending_fifo.sv
// fetch_pending_fifo: synchronous first-word-fall-through FIFO.
// Ports: clk, rst (sync active-low), push/wdata, pop/rdata (head),
// full, empty, count (entries held).
module fetch_pending_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: replays a programmed address list over the
// req/grant/rvalid memory protocol with several requests in flight.
// Ports: list load (seq_wr_en/seq_wr_addr/seq_clear), control
// (start/busy/done/proto_err), memory side (instr_req/addr/grant/
// rvalid/rdata), response side (resp_valid/ready/addr/data/latency).
module instr_fetch_sequencer
    import ryuki_datatypes::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SEQ_DEPTH       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DEPTH      = 8,
    parameter int LAT_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seq_wr_en,
    input  logic [ADDR_WIDTH-1:0] seq_wr_addr,
    input  logic                  seq_clear,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  proto_err,
    output logic                  instr_req,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [LAT_WIDTH-1:0]  resp_latency
);

    localparam int SIW = $clog2(SEQ_DEPTH);
    localparam int SCW = SIW + 1;
    localparam int PW  = ADDR_WIDTH + LAT_WIDTH;
    localparam int RW  = ADDR_WIDTH + DATA_WIDTH + LAT_WIDTH;
    localparam int PCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int RCW = $clog2(RESP_DEPTH + 1);

    fetch_seq_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] seq_mem_q [SEQ_DEPTH];
    logic [ADDR_WIDTH-1:0] seq_mem_d [SEQ_DEPTH];
    logic [SCW-1:0]        seq_count_q, seq_count_d;
    logic [SCW-1:0]        ptr_q, ptr_d;
    logic [LAT_WIDTH-1:0]  ts_q, ts_d;
    logic                  proto_err_q, proto_err_d;

    logic [PW-1:0]  pend_wdata, pend_rdata;
    logic           pend_push, pend_pop, pend_full, pend_empty;
    logic [PCW-1:0] pend_count;
    logic [RW-1:0]  resp_wdata, resp_rdata;
    logic           resp_push, resp_pop, resp_full, resp_empty;
    logic [RCW-1:0] resp_count;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           credit_sum;
    logic                  credit_ok;
    logic                  grant, last_grant, rvalid_ok;

    // ---- sequence list ----
    always_comb begin
        seq_mem_d   = seq_mem_q;
        seq_count_d = seq_count_q;
        if (state_q == IDLE) begin
            if (seq_clear) begin
                seq_count_d = '0;
            end else if (seq_wr_en &&
                         seq_count_q < SCW'(SEQ_DEPTH)) begin
                seq_mem_d[seq_count_q[SIW-1:0]] = seq_wr_addr;
                seq_count_d = seq_count_q + SCW'(1);
            end
        end
    end

    // ---- issue ----
    // Slots in flight plus queued responses never exceed the
    // response FIFO, so an rvalid always has somewhere to land.
    // While a request waits for grant this sum cannot grow, which
    // keeps instr_req/instr_addr stable until accepted.
    always_comb begin
        cur_addr   = seq_mem_q[ptr_q[SIW-1:0]];
        credit_sum = 32'(pend_count) + 32'(resp_count);
        credit_ok  = !pend_full && (credit_sum < 32'(RESP_DEPTH));
        instr_req  = (state_q == RUN) && (ptr_q < seq_count_q)
                     && credit_ok;
        instr_addr = instr_req ? cur_addr : '0;
        grant      = instr_req && instr_grant;
        last_grant = grant && (ptr_q == seq_count_q - SCW'(1));
        ptr_d      = (state_q == IDLE) ? '0
                   : grant ? ptr_q + SCW'(1) : ptr_q;
    end

    // ---- completion ----
    always_comb begin
        ts_d        = ts_q + LAT_WIDTH'(1);
        rvalid_ok   = instr_rvalid && !pend_empty;
        proto_err_d = proto_err_q || (instr_rvalid && pend_empty);
        pend_push   = grant && !pend_full;
        pend_wdata  = {cur_addr, ts_q};
        pend_pop    = rvalid_ok;
        resp_push   = rvalid_ok && !resp_full;
        // Latency wraps modulo 2^LAT_WIDTH.
        resp_wdata  = {pend_rdata[PW-1:LAT_WIDTH], instr_rdata,
                       ts_q - pend_rdata[LAT_WIDTH-1:0]};
        resp_valid  = !resp_empty;
        resp_pop    = resp_valid && resp_ready;
        resp_addr   = resp_rdata[RW-1 -: ADDR_WIDTH];
        resp_data   = resp_rdata[LAT_WIDTH +: DATA_WIDTH];
        resp_latency = resp_rdata[LAT_WIDTH-1:0];
        proto_err   = proto_err_q;
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (seq_count_q != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_grant) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pend_empty) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    // ---- datapath registers ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SEQ_DEPTH; i++) begin
                seq_mem_q[i] <= '0;
            end
            seq_count_q <= '0;
            ptr_q       <= '0;
            ts_q        <= '0;
            proto_err_q <= 1'b0;
        end else begin
            seq_mem_q   <= seq_mem_d;
            seq_count_q <= seq_count_d;
            ptr_q       <= ptr_d;
            ts_q        <= ts_d;
            proto_err_q <= proto_err_d;
        end
    end

    fetch_pending_fifo #(
        .WIDTH (PW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_push),
        .wdata (pend_wdata),
        .pop   (pend_pop),
        .rdata (pend_rdata),
        .full  (pend_full),
        .empty (pend_empty),
        .count (pend_count)
    );

    fetch_pending_fifo #(
        .WIDTH (RW),
        .DEPTH (RESP_DEPTH)
    ) u_resp (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_push),
        .wdata (resp_wdata),
        .pop   (resp_pop),
        .rdata (resp_rdata),
        .full  (resp_full),
        .empty (resp_empty),
        .count (resp_count)
    );

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed bench for instr_fetch_sequencer.
// Drives a latency-configurable memory model and checks responses.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        seq_wr_en;
    logic [31:0] seq_wr_addr;
    logic        seq_clear;
    logic        start;
    logic        busy, done, proto_err;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_grant;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;
    logic [7:0]  resp_latency;

    instr_fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .seq_wr_en    (seq_wr_en),
        .seq_wr_addr  (seq_wr_addr),
        .seq_clear    (seq_clear),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .proto_err    (proto_err),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_grant  (instr_grant),
        .instr_rvalid (instr_rvalid),
        .instr_rdata  (instr_rdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_addr    (resp_addr),
        .resp_data    (resp_data),
        .resp_latency (resp_latency)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] lst[$];

    int n_chk = 0;
    int n_fail = 0;
    int ncyc = 0;
    int mlat = 1;
    int os = 0;
    int max_os, grants, first_g, last_g;
    int nrsp, done_cnt, held, hold_err;
    int blk_left = 0;
    int lag;
    bit gnt_en = 1'b1;
    bit inject = 1'b0;
    bit prev_wait = 1'b0;
    bit req_seen;
    logic [31:0] blk_addr = 32'hffff_fffc;
    logic [31:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    task automatic mem_step();
        mreq_t m;
        instr_rvalid = 1'b0;
        instr_rdata  = '0;
        instr_grant  = 1'b0;
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            os = 0;
            prev_wait = 1'b0;
        end else begin
            if (mq.size() > 0 && mq[0].due == ncyc) begin
                instr_rvalid = 1'b1;
                instr_rdata  = mdata(mq[0].addr);
                void'(mq.pop_front());
                os--;
            end else if (inject) begin
                instr_rvalid = 1'b1;
                instr_rdata  = 32'hbad0_0bad;
            end
            if (prev_wait &&
                !(instr_req && instr_addr == prev_addr)) begin
                hold_err++;
            end
            if (instr_req && instr_addr == blk_addr && blk_left > 0) begin
                blk_left--;
                held++;
            end else if (instr_req && gnt_en) begin
                instr_grant = 1'b1;
                m.addr = instr_addr;
                m.due  = ncyc + mlat;
                mq.push_back(m);
                os++;
                grants++;
                if (first_g < 0) first_g = ncyc;
                last_g = ncyc;
            end
            prev_wait = instr_req && !instr_grant;
            prev_addr = instr_addr;
            if (os > max_os) max_os = os;
        end
        ncyc++;
    endtask

    task automatic rsp_step();
        if (rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_extra", resp_addr, 32'hffff_ffff);
            end else begin
                chk("rsp_addr", resp_addr, exp_q[0]);
                chk("rsp_data", resp_data, mdata(exp_q[0]));
                chk("rsp_lat", 32'(resp_latency), mlat);
                void'(exp_q.pop_front());
            end
            nrsp++;
        end
    endtask

    task automatic cycle();
        mem_step();
        rsp_step();
        @(negedge clk);
        if (done) done_cnt++;
        if (instr_req) req_seen = 1'b1;
    endtask

    task automatic clr();
        grants = 0; first_g = -1; last_g = -1; max_os = 0;
        nrsp = 0; done_cnt = 0; held = 0; hold_err = 0;
        req_seen = 1'b0;
    endtask

    task automatic clear_list();
        seq_clear = 1'b1;
        cycle();
        seq_clear = 1'b0;
    endtask

    task automatic load();
        foreach (lst[i]) begin
            seq_wr_en   = 1'b1;
            seq_wr_addr = lst[i];
            cycle();
        end
        seq_wr_en   = 1'b0;
        seq_wr_addr = '0;
    endtask

    task automatic arm_kick();
        foreach (lst[i]) exp_q.push_back(lst[i]);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++) cycle();
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
        repeat (12) cycle();
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_nrsp"}, nrsp, lst.size());
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_hold"}, hold_err, 0);
        chk({tag, "_proto"}, 32'(proto_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; seq_wr_en = 1'b0; seq_wr_addr = '0;
        seq_clear = 1'b0; start = 1'b0; resp_ready = 1'b1;
        instr_grant = 1'b0; instr_rvalid = 1'b0; instr_rdata = '0;
        clr();
        @(negedge clk);
        repeat (3) cycle();
        chk("rst_req", 32'(instr_req), 0);
        chk("rst_addr", instr_addr, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_proto", 32'(proto_err), 0);
        chk("rst_rvalid", 32'(resp_valid), 0);
        chk("rst_raddr", resp_addr, 0);
        chk("rst_rlat", 32'(resp_latency), 0);
        rst = 1'b1;
        cycle();

        // latency 1, ready always high
        lst = '{32'h80, 32'h0, 32'h4, 32'h8};
        load();
        mlat = 1; clr();
        arm_kick();
        finish_run("lat1", 100);
        chk("lat1_grants", grants, 4);

        // latency 3, list retained, replay from entry 0
        mlat = 3; clr();
        arm_kick();
        finish_run("lat3", 100);
        chk("lat3_grants", grants, 4);
        chk("lat3_b2b", last_g - first_g, 3);
        chk("lat3_peak", 32'(max_os >= 3 && max_os <= 4), 1);

        // backpressure: response credit limits issue
        clear_list();
        lst.delete();
        for (int i = 0; i < 13; i++) lst.push_back(32'h100 + 32'(4 * i));
        load();
        mlat = 1; clr(); resp_ready = 1'b0;
        arm_kick();
        repeat (40) cycle();
        chk("bp_grants", grants, 8);
        chk("bp_req_low", 32'(instr_req), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_rvalid", 32'(resp_valid), 1);
        chk("bp_nrsp", nrsp, 0);
        resp_ready = 1'b1;
        finish_run("bp", 200);
        chk("bp_grants_all", grants, 13);

        // grant withheld 5 cycles on 0x48
        clear_list();
        lst = '{32'h40, 32'h44, 32'h48, 32'h4c};
        load();
        mlat = 2; clr();
        blk_addr = 32'h48; blk_left = 5;
        arm_kick();
        finish_run("hold", 100);
        chk("hold_cycles", held, 5);
        blk_addr = 32'hffff_fffc; blk_left = 0;

        // empty list, then stray rvalid
        clear_list();
        lst.delete();
        clr();
        start = 1'b1;
        cycle();
        start = 1'b0;
        lag = 1;
        while (done_cnt == 0 && lag < 5) begin
            cycle();
            lag++;
        end
        chk("empty_done_lag", 32'(lag >= 1 && lag <= 2), 1);
        repeat (3) cycle();
        chk("empty_done_once", done_cnt, 1);
        chk("empty_no_req", 32'(req_seen), 0);
        chk("proto_pre", 32'(proto_err), 0);
        inject = 1'b1;
        cycle();
        inject = 1'b0;
        cycle();
        chk("proto_set", 32'(proto_err), 1);
        chk("proto_no_rsp", 32'(resp_valid), 0);
        repeat (3) cycle();
        chk("proto_sticky", 32'(proto_err), 1);

        // reset with two requests in flight
        lst = '{32'h10, 32'h14, 32'h18, 32'h1c};
        load();
        mlat = 6; clr();
        arm_kick();
        for (int i = 0; i < 20 && os < 2; i++) cycle();
        chk("mid_os2", os, 2);
        gnt_en = 1'b0;
        rst = 1'b0;
        cycle();
        chk("mid_req", 32'(instr_req), 0);
        chk("mid_rvalid", 32'(resp_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_proto", 32'(proto_err), 0);
        cycle();
        rst = 1'b1; gnt_en = 1'b1; mlat = 1;
        cycle();
        load();
        clr();
        arm_kick();
        finish_run("replay", 100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
